// File: rtl/eq_mix_engine_pkg.sv
// Shared types and width helpers for the eq_mix_engine band-sum/volume stage.
// Width functions keep the shared multiplier and accumulator wrap-free for any input.
package eq_mix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    VOL  = 2'd2,
    DONE = 2'd3
  } eq_state_e;

  typedef struct packed {
    logic signed [63:0] val;
    logic               clip;
  } sat_t;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int prod_w(input int smpl_w, input int gain_w);
    return smpl_w + gain_w + 1;
  endfunction

  function automatic int acc_w(input int smpl_w, input int gain_w, input int nb);
    return prod_w(smpl_w, gain_w) + $clog2(nb);
  endfunction

  // Accumulator after removing the gain fraction bits.
  function automatic int mix_w(input int smpl_w, input int gain_w, input int nb);
    return acc_w(smpl_w, gain_w, nb) - (gain_w - 2);
  endfunction

  // Product width of the shared multiplier, covering both band and volume phases.
  function automatic int volp_w(input int smpl_w, input int gain_w, input int vol_w, input int nb);
    return max_i(smpl_w, mix_w(smpl_w, gain_w, nb)) + max_i(gain_w, vol_w) + 1;
  endfunction

  function automatic sat_t sat_to_w(input logic signed [63:0] v, input int w);
    sat_t               r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.clip = 1'b1;
    if (v > hi)      r.val = hi;
    else if (v < lo) r.val = lo;
    else begin
      r.val  = v;
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/eq_mix_engine_if.sv
// Frame input / mixed output bundle of eq_mix_engine.
// master = FIR bank side driving frames, slave = the engine.
interface eq_mix_engine_if #(
  parameter int NUM_CH    = 2,
  parameter int NUM_BANDS = 5,
  parameter int SMPL_W    = 16,
  parameter int GAIN_W    = 12,
  parameter int VOL_W     = 12
);
  logic                                in_vld;
  logic                                in_rdy;
  logic [NUM_CH*NUM_BANDS*SMPL_W-1:0]  band_smpl;
  logic [NUM_BANDS*GAIN_W-1:0]         band_gain;
  logic [VOL_W-1:0]                    volume;
  logic [NUM_CH*SMPL_W-1:0]            out_smpl;
  logic                                out_vld;
  logic                                ovr_err;

  modport master (
    output in_vld, band_smpl, band_gain, volume,
    input  in_rdy, out_smpl, out_vld, ovr_err
  );

  modport slave (
    input  in_vld, band_smpl, band_gain, volume,
    output in_rdy, out_smpl, out_vld, ovr_err
  );
endinterface

// File: rtl/eq_mix_engine_mac.sv
// Single signed multiplier plus accumulator, shared by the band MAC and volume phases.
// sel_vol swaps the operands from (sample, gain) to (acc >>> frac, volume).
module eq_mix_mac
  import eq_mix_pkg::*;
#(
  parameter int SMPL_W    = 16,
  parameter int GAIN_W    = 12,
  parameter int VOL_W     = 12,
  parameter int NUM_BANDS = 5,
  localparam int AW   = acc_w(SMPL_W, GAIN_W, NUM_BANDS),
  localparam int MW   = mix_w(SMPL_W, GAIN_W, NUM_BANDS),
  localparam int OA_W = max_i(SMPL_W, MW),
  localparam int OB_W = max_i(GAIN_W, VOL_W) + 1,
  localparam int PW   = volp_w(SMPL_W, GAIN_W, VOL_W, NUM_BANDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sel_vol,
  input  logic                     acc_ld,
  input  logic                     acc_en,
  input  logic signed [SMPL_W-1:0] smpl,
  input  logic [GAIN_W-1:0]        gain,
  input  logic [VOL_W-1:0]         volume,
  output logic signed [PW-1:0]     prod
);

  logic signed [AW-1:0]   acc;
  logic signed [OA_W-1:0] op_a;
  logic signed [OB_W-1:0] op_b;
  logic signed [OA_W-1:0] mix;

  // Floor division by the gain unity value; the slice is sign-extended back up.
  assign mix = OA_W'($signed(acc[AW-1:GAIN_W-2]));

  always_comb begin
    op_a = OA_W'(smpl);
    op_b = OB_W'({1'b0, gain});
    if (sel_vol) begin
      op_a = mix;
      op_b = OB_W'({1'b0, volume});
    end
  end

  assign prod = op_a * op_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (acc_ld) begin
      acc <= AW'(prod);
    end else if (acc_en) begin
      acc <= acc + AW'(prod);
    end
  end

endmodule

// File: rtl/eq_mix_engine.sv
// Band-sum and volume stage: per-channel gain MAC, volume scale, saturation, overrun flag.
// Optional CLIP_CNT_EN adds a 16-bit saturating count of clipped channel results.
module eq_mix_engine
  import eq_mix_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int NUM_BANDS = 5,
  parameter int SMPL_W    = 16,
  parameter int GAIN_W    = 12,
  parameter int VOL_W     = 12
) (
  input  logic           clk,
  input  logic           rst,
  eq_mix_engine_if.slave bus
`ifdef CLIP_CNT_EN
  ,
  output logic [15:0]    clip_cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for a frame, in_rdy high
  // MAC   | one band per cycle into the accumulator for channel ch_cnt
  // VOL   | volume scale + saturate, write channel slot of holding register
  // DONE  | publish holding register, pulse out_vld
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_MAC  = MAC;
  localparam logic [1:0] S_VOL  = VOL;
  localparam logic [1:0] S_DONE = DONE;

  localparam int BW = max_i(1, $clog2(NUM_BANDS));
  localparam int CW = max_i(1, $clog2(NUM_CH));
  localparam int PW = volp_w(SMPL_W, GAIN_W, VOL_W, NUM_BANDS);

  logic [1:0]                         state;
  logic [BW-1:0]                      band_cnt;
  logic [CW-1:0]                      ch_cnt;
  logic [NUM_CH*NUM_BANDS*SMPL_W-1:0] smpl_q;
  logic [NUM_BANDS*GAIN_W-1:0]        gain_q;
  logic [VOL_W-1:0]                   vol_q;
  logic [NUM_CH*SMPL_W-1:0]           hold_q;
  logic [NUM_CH*SMPL_W-1:0]           out_smpl_q;
  logic                               out_vld_q;
  logic                               ovr_q;
  logic                               accept;
  logic signed [SMPL_W-1:0]           cur_smpl;
  logic [GAIN_W-1:0]                  cur_gain;
  logic signed [PW-1:0]               prod;
  sat_t                               vol_sat;
  int                                 smpl_idx;

  assign bus.in_rdy   = (state == S_IDLE) && !rst;
  assign bus.out_smpl = out_smpl_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.ovr_err  = ovr_q;
  assign accept       = bus.in_vld && bus.in_rdy;

  always_comb begin
    smpl_idx = int'(ch_cnt) * NUM_BANDS + int'(band_cnt);
    cur_smpl = smpl_q[smpl_idx*SMPL_W +: SMPL_W];
    cur_gain = gain_q[int'(band_cnt)*GAIN_W +: GAIN_W];
    vol_sat  = sat_to_w(64'(prod) >>> VOL_W, SMPL_W);
  end

  eq_mix_mac #(
    .SMPL_W    (SMPL_W),
    .GAIN_W    (GAIN_W),
    .VOL_W     (VOL_W),
    .NUM_BANDS (NUM_BANDS)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .sel_vol (state == S_VOL),
    .acc_ld  ((state == S_MAC) && (band_cnt == '0)),
    .acc_en  (state == S_MAC),
    .smpl    (cur_smpl),
    .gain    (cur_gain),
    .volume  (vol_q),
    .prod    (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      band_cnt   <= '0;
      ch_cnt     <= '0;
      smpl_q     <= '0;
      gain_q     <= '0;
      vol_q      <= '0;
      hold_q     <= '0;
      out_smpl_q <= '0;
      out_vld_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      out_vld_q <= 1'b0;
      if (bus.in_vld && !bus.in_rdy) ovr_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            smpl_q   <= bus.band_smpl;
            gain_q   <= bus.band_gain;
            vol_q    <= bus.volume;
            band_cnt <= '0;
            ch_cnt   <= '0;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          if (band_cnt == BW'(NUM_BANDS - 1)) begin
            band_cnt <= '0;
            state    <= S_VOL;
          end else begin
            band_cnt <= band_cnt + 1'b1;
          end
        end
        S_VOL: begin
          hold_q[int'(ch_cnt)*SMPL_W +: SMPL_W] <= SMPL_W'(vol_sat.val);
          if (ch_cnt == CW'(NUM_CH - 1)) begin
            ch_cnt <= '0;
            state  <= S_DONE;
          end else begin
            ch_cnt <= ch_cnt + 1'b1;
            state  <= S_MAC;
          end
        end
        S_DONE: begin
          out_smpl_q <= hold_q;
          out_vld_q  <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CLIP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_cnt <= '0;
    end else if ((state == S_VOL) && vol_sat.clip && (clip_cnt != 16'hFFFF)) begin
      clip_cnt <= clip_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eq_mix_engine.sv
// Self-checking bench for eq_mix_engine: constant vector table, hand sequences,
// and random frames scored against an arithmetic reference model.
module tb_eq_mix_engine;
  localparam int NC  = 2;
  localparam int NB  = 5;
  localparam int SW  = 16;
  localparam int GW  = 12;
  localparam int VW  = 12;
  localparam int LAT = NC * (NB + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eq_mix_engine_if #(.NUM_CH(NC), .NUM_BANDS(NB), .SMPL_W(SW), .GAIN_W(GW), .VOL_W(VW)) bus ();
`ifdef CLIP_CNT_EN
  logic [15:0] clip_cnt;
`endif

  eq_mix_engine #(.NUM_CH(NC), .NUM_BANDS(NB), .SMPL_W(SW), .GAIN_W(GW), .VOL_W(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CLIP_CNT_EN
    ,
    .clip_cnt (clip_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Reference: sum of sample*gain, drop gain fraction, scale by volume, clamp.
  function automatic logic [NC*SW-1:0] model(input logic [NC*NB*SW-1:0] s,
                                             input logic [NB*GW-1:0] g,
                                             input logic [VW-1:0] v,
                                             output int nclip);
    longint acc, mix, y, smax, smin;
    logic [NC*SW-1:0] r;
    r     = '0;
    nclip = 0;
    smax  = (64'sd1 <<< (SW - 1)) - 1;
    smin  = -smax - 1;
    for (int c = 0; c < NC; c++) begin
      acc = 0;
      for (int b = 0; b < NB; b++)
        acc += longint'($signed(s[(c*NB+b)*SW +: SW])) * longint'(g[b*GW +: GW]);
      mix = acc >>> (GW - 2);
      y   = (mix * longint'(v)) >>> VW;
      if (y > smax) begin
        y = smax;
        nclip++;
      end else if (y < smin) begin
        y = smin;
        nclip++;
      end
      r[c*SW +: SW] = SW'(y);
    end
    return r;
  endfunction

  typedef struct {
    logic [NC*SW-1:0] exp;
    int               nclip;
    int               cyc;
  } sb_t;

  sb_t sbq[$];
  int  cyc     = 0;
  int  n_acc   = 0;
  int  n_out   = 0;
  int  exp_clip = 0;

  always @(posedge clk) begin
    sb_t e;
    int  nc;
    cyc++;
    if (rst) begin
      sbq.delete();
      exp_clip = 0;
    end else if (bus.in_vld && bus.in_rdy) begin
      e.exp   = model(bus.band_smpl, bus.band_gain, bus.volume, nc);
      e.nclip = nc;
      e.cyc   = cyc;
      sbq.push_back(e);
      n_acc++;
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (!rst && bus.out_vld) begin
      n_out++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_out_vld: got out_vld=1, expected 0 with no frame in flight");
      end else begin
        e = sbq.pop_front();
        chk("sb_out_smpl", longint'(bus.out_smpl), longint'(e.exp));
        chk("sb_latency", longint'(cyc - e.cyc), LAT);
`ifdef CLIP_CNT_EN
        exp_clip = (exp_clip + e.nclip > 65535) ? 65535 : exp_clip + e.nclip;
        chk("sb_clip_cnt", longint'(clip_cnt), exp_clip);
`endif
      end
    end
  end

  task automatic set_uniform(input int s0, input int s1, input int g, input int v);
    for (int c = 0; c < NC; c++)
      for (int b = 0; b < NB; b++)
        bus.band_smpl[(c*NB+b)*SW +: SW] = SW'((c == 0) ? s0 : s1);
    for (int b = 0; b < NB; b++) bus.band_gain[b*GW +: GW] = GW'(g);
    bus.volume = VW'(v);
  endtask

  task automatic set_random();
    for (int k = 0; k < NC*NB; k++) begin
      case ($urandom_range(0, 7))
        0:       bus.band_smpl[k*SW +: SW] = 16'h8000;
        1:       bus.band_smpl[k*SW +: SW] = 16'h7FFF;
        default: bus.band_smpl[k*SW +: SW] = SW'($urandom);
      endcase
    end
    for (int b = 0; b < NB; b++) bus.band_gain[b*GW +: GW] = GW'($urandom_range(0, 4095));
    case ($urandom_range(0, 5))
      0:       bus.volume = '0;
      1:       bus.volume = 12'hFFF;
      default: bus.volume = VW'($urandom);
    endcase
  endtask

  // Raises in_vld only while in_rdy is high, so no overrun is produced here.
  task automatic send(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_rdy) ok = 1'b1;
    end
    if (ok) begin
      bus.in_vld = 1'b1;
      @(posedge clk);
      #1;
      bus.in_vld = 1'b0;
    end else begin
      timeout_fail("send_in_rdy");
    end
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_vld) ok = 1'b1;
    end
    if (!ok) timeout_fail("wait_out_vld");
  endtask

  typedef struct {
    int s0, s1, g, v, e0, e1, eclip;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n0;
    int clip0;
    tbl[0] = '{100,    -100,   1024, 4095,    499,   -500, 0};
    tbl[1] = '{30000,  -30000, 4095, 4095,  32767, -32768, 2};
    tbl[2] = '{-32768, -32768, 0,    4095,      0,      0, 0};
    tbl[3] = '{-32768, 32767,  4095, 0,         0,      0, 0};
    tbl[4] = '{1000,   -1,     1024, 2048,   2500,     -3, 0};
    tbl[5] = '{-32768, 32767,  4095, 4095, -32768,  32767, 2};
    clip0 = 0;

    bus.in_vld    = 1'b0;
    bus.band_smpl = '0;
    bus.band_gain = '0;
    bus.volume    = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", bus.in_rdy, 0);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_smpl", longint'(bus.out_smpl), 0);
    chk("rst_ovr_err", bus.ovr_err, 0);
`ifdef CLIP_CNT_EN
    chk("rst_clip_cnt", longint'(clip_cnt), 0);
`endif
    rst = 1'b0;
    #1;
    chk("in_rdy_after_release", bus.in_rdy, 1);

    for (int i = 0; i < 6; i++) begin
`ifdef CLIP_CNT_EN
      clip0 = int'(clip_cnt);
`endif
      set_uniform(tbl[i].s0, tbl[i].s1, tbl[i].g, tbl[i].v);
      send(ok);
      wait_out(ok);
      chk($sformatf("vec%0d_ch0", i), longint'($signed(bus.out_smpl[SW-1:0])), tbl[i].e0);
      chk($sformatf("vec%0d_ch1", i), longint'($signed(bus.out_smpl[2*SW-1:SW])), tbl[i].e1);
      chk($sformatf("vec%0d_rdy_with_vld", i), bus.in_rdy, 1);
`ifdef CLIP_CNT_EN
      chk($sformatf("vec%0d_clip", i), longint'(clip_cnt),
          (clip0 + tbl[i].eclip > 65535) ? 65535 : clip0 + tbl[i].eclip);
`endif
    end

    repeat (5) @(negedge clk);
    chk("hold_ch0", longint'($signed(bus.out_smpl[SW-1:0])), tbl[5].e0);
    chk("hold_ch1", longint'($signed(bus.out_smpl[2*SW-1:SW])), tbl[5].e1);
    chk("hold_out_vld_low", bus.out_vld, 0);

    // Inputs trashed right after the accept edge must not reach the frame in flight.
    set_uniform(100, -100, 1024, 4095);
    send(ok);
    bus.band_gain = '0;
    bus.volume    = '0;
    set_random();
    bus.band_gain = '0;
    bus.volume    = '0;
    wait_out(ok);
    chk("snap_ch0", longint'($signed(bus.out_smpl[SW-1:0])), 499);
    chk("snap_ch1", longint'($signed(bus.out_smpl[2*SW-1:SW])), -500);

    for (int f = 0; f < 24; f++) begin
      set_random();
      send(ok);
      repeat ($urandom_range(0, 16)) @(posedge clk);
    end
    repeat (20) @(negedge clk);
    chk("rand_all_out", n_out, n_acc);
    chk("ovr_clear_before_cont", bus.ovr_err, 0);

    n0 = n_acc;
    @(negedge clk);
    bus.in_vld = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      set_random();
    end
    bus.in_vld = 1'b0;
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    chk("cont_drained", sbq.size(), 0);
    chk("cont_accepts_ge4", (n_acc - n0) >= 4, 1);
    chk("cont_ovr_err", bus.ovr_err, 1);
    chk("cont_all_out", n_out, n_acc);

    set_uniform(30000, -30000, 4095, 4095);
    send(ok);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_rdy", bus.in_rdy, 1);
    chk("midrst_out_smpl", longint'(bus.out_smpl), 0);
    chk("midrst_out_vld", bus.out_vld, 0);
    chk("midrst_ovr_err", bus.ovr_err, 0);
`ifdef CLIP_CNT_EN
    chk("midrst_clip_cnt", longint'(clip_cnt), 0);
`endif
    n0 = n_out;
    repeat (20) @(negedge clk);
    chk("midrst_no_out_vld", n_out, n0);
    set_uniform(100, -100, 1024, 4095);
    send(ok);
    wait_out(ok);
    chk("post_rst_ch0", longint'($signed(bus.out_smpl[SW-1:0])), 499);
    chk("post_rst_ch1", longint'($signed(bus.out_smpl[2*SW-1:SW])), -500);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
